deshifrator_accum: RTL

DESHIFRATOR_ACCUM -- requirements
Module: deshifrator_accum

---
 rtl/deshifrator_pkg.sv | 11 +
 rtl/deshifrator.sv | 23 ++
 rtl/deshifrator_accum.sv | 95 +++++++++
 3 files changed

// File: rtl/deshifrator_pkg.sv
// Shared definitions for the position-decode accumulator: FSM states and default vector width.
package deshifrator_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/deshifrator.sv
// Combinational decoder: position code to one-hot vector, all-zero when the code is out of range.
module deshifrator
    import deshifrator_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned POS_W  = $clog2(DATA_W)
) (
    input  logic [POS_W-1:0]  pos,
    output logic [DATA_W-1:0] onehot_c,
    output logic              in_range_c
);

    always_comb begin
        onehot_c   = '0;
        in_range_c = 1'b0;
        // Codes past DATA_W only exist for non-power-of-two widths.
        if (32'(pos) < DATA_W) begin
            in_range_c    = 1'b1;
            onehot_c[pos] = 1'b1;
        end
    end

endmodule

// File: rtl/deshifrator_accum.sv
// Accumulates one-hot decodes of position beats into a vector per frame and presents the
// result with a distinct-bit count and a duplicate/out-of-range error flag.
module deshifrator_accum
    import deshifrator_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned POS_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  in_pos,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [POS_W:0]    out_count,
    output logic              out_err
);

    state_t            state;
    logic [DATA_W-1:0] mask;
    logic [POS_W:0]    count;
    logic              err;

    logic [DATA_W-1:0] dec;
    logic              in_range;
    logic              dup;
    logic [DATA_W-1:0] mask_nx;
    logic [POS_W:0]    count_nx;
    logic              err_nx;

    deshifrator #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_dec (
        .pos        (in_pos),
        .onehot_c   (dec),
        .in_range_c (in_range)
    );

    // Frame state as it would be after absorbing the current beat.
    always_comb begin
        dup      = |(mask & dec);
        mask_nx  = mask | dec;
        count_nx = count + (POS_W+1)'(in_range && !dup);
        err_nx   = err | dup | !in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mask      <= '0;
            count     <= '0;
            err       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_data  <= mask_nx;
                            out_count <= count_nx;
                            out_err   <= err_nx;
                            mask      <= '0;
                            count     <= '0;
                            err       <= 1'b0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            mask  <= mask_nx;
                            count <= count_nx;
                            err   <= err_nx;
                        end
                    end
                end
                HOLD: begin
                    // Result registers stay untouched until the next frame closes.
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
